// File: rtl/conv_result_requantizer_pkg.sv
// Shared settings for the convolution datapath: sample widths and requantizer constants.
// The optional saturation counter in the requantizer is enabled by CONV_RQ_SAT_COUNT_EN.
package conv_result_requantizer_pkg;

    localparam int DATA_SIZE  = 16;
    localparam int EXTRA_BITS = 4;
    localparam int FULL_SIZE  = 2*DATA_SIZE + EXTRA_BITS;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    localparam int RQ_SHIFT          = DATA_SIZE - 1;
    localparam int RQ_FIFO_DEPTH     = 8;
    localparam int RQ_FIFO_ADDR_SIZE = clog2(RQ_FIFO_DEPTH);
    localparam int RQ_WORD_SIZE      = DATA_SIZE + 1;

endpackage

// File: rtl/rq_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module rq_sync_fifo
    import conv_result_requantizer_pkg::*;
#(
    parameter int WIDTH = RQ_WORD_SIZE,
    parameter int DEPTH = RQ_FIFO_DEPTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_push,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          o_rdata,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [clog2(DEPTH):0]     o_level
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_level = r_level;
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // When full with a simultaneous pop, the write lands in the slot being vacated.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/conv_result_requantizer.sv
// Requantizes full-precision conv results (round-half-up shift + saturation) into a FWFT FIFO.
// Define CONV_RQ_SAT_COUNT_EN to add the saturating sat_count output.
module conv_result_requantizer #(
    parameter int DATA_SIZE  = conv_result_requantizer_pkg::DATA_SIZE,
    parameter int FULL_SIZE  = conv_result_requantizer_pkg::FULL_SIZE,
    parameter int RQ_SHIFT   = conv_result_requantizer_pkg::RQ_SHIFT,
    parameter int FIFO_DEPTH = conv_result_requantizer_pkg::RQ_FIFO_DEPTH
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic [FULL_SIZE-1:0]                            in_data,
    input  logic                                            in_valid,
    output logic [DATA_SIZE-1:0]                            out_data,
    output logic                                            out_sat,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [conv_result_requantizer_pkg::clog2(FIFO_DEPTH):0] fifo_level,
    output logic                                            overflow
`ifdef CONV_RQ_SAT_COUNT_EN
    ,
    output logic [15:0]                                     sat_count
`endif
);

    import conv_result_requantizer_pkg::*;

    localparam int WORD_W = DATA_SIZE + 1;
    localparam int RND_SH = (RQ_SHIFT > 0) ? RQ_SHIFT - 1 : 0;
    localparam logic signed [FULL_SIZE:0] RND =
        (RQ_SHIFT > 0) ? ((FULL_SIZE+1)'(1) << RND_SH) : '0;
    localparam logic signed [FULL_SIZE:0] SAT_HI = (FULL_SIZE+1)'((2**(DATA_SIZE-1)) - 1);
    localparam logic signed [FULL_SIZE:0] SAT_LO = -((FULL_SIZE+1)'(2**(DATA_SIZE-1)));

    logic [1:0]                  r_vld_pipe;
    logic signed [FULL_SIZE:0]   w_ext;
    logic signed [FULL_SIZE:0]   w_rnd;
    logic signed [FULL_SIZE:0]   r_s1;
    logic [DATA_SIZE-1:0]        w_s2_data;
    logic                        w_s2_sat;
    logic [DATA_SIZE-1:0]        r_s2_data;
    logic                        r_s2_sat;
    logic [WORD_W-1:0]           w_rdata;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_pop;
    logic                        w_drop;
    logic                        r_overflow;

    // One extra bit so the rounding add cannot wrap at the positive extreme.
    assign w_ext = $signed({in_data[FULL_SIZE-1], in_data});
    assign w_rnd = w_ext + RND;

    always_comb begin
        w_s2_sat  = 1'b0;
        w_s2_data = r_s1[DATA_SIZE-1:0];
        if (r_s1 > SAT_HI) begin
            w_s2_sat  = 1'b1;
            w_s2_data = {1'b0, {(DATA_SIZE-1){1'b1}}};
        end else if (r_s1 < SAT_LO) begin
            w_s2_sat  = 1'b1;
            w_s2_data = {1'b1, {(DATA_SIZE-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], in_valid};
        end
    end

    always_ff @(posedge clk) begin
        r_s1      <= w_rnd >>> RQ_SHIFT;
        r_s2_data <= w_s2_data;
        r_s2_sat  <= w_s2_sat;
    end

    rq_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_push  (r_vld_pipe[1]),
        .i_wdata ({r_s2_sat, r_s2_data}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign w_pop     = ~w_empty & out_ready;
    assign w_drop    = r_vld_pipe[1] & w_full & ~w_pop;
    assign out_valid = ~w_empty;
    assign out_data  = w_rdata[DATA_SIZE-1:0];
    assign out_sat   = w_rdata[DATA_SIZE];
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef CONV_RQ_SAT_COUNT_EN
    logic [15:0] r_sat_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sat_count <= '0;
        end else if (r_vld_pipe[1] && !w_drop && r_s2_sat && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count = r_sat_count;
`endif

endmodule

// File: tb/tb_conv_result_requantizer.sv
// Directed bench for conv_result_requantizer: rounding/saturation table, backpressure, full+pop, mid-stream reset.
module tb_conv_result_requantizer;

    localparam int DW = 16;
    localparam int FW = 36;
    localparam int NV = 14;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [FW-1:0] in_data;
    logic          in_valid;
    logic [DW-1:0] out_data;
    logic          out_sat;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    fifo_level;
    logic          overflow;
`ifdef CONV_RQ_SAT_COUNT_EN
    logic [15:0]   sat_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic signed [FW-1:0] din;
        logic signed [DW-1:0] dout;
        logic                 sat;
    } vec_t;

    vec_t vt [NV];

    conv_result_requantizer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
`ifdef CONV_RQ_SAT_COUNT_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input longint v);
        in_data  = FW'(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        vt[0]  = '{36'sd16384,       16'sd1,      1'b0};
        vt[1]  = '{36'sd16383,       16'sd0,      1'b0};
        vt[2]  = '{36'sd49152,       16'sd2,      1'b0};
        vt[3]  = '{-36'sd16384,      16'sd0,      1'b0};
        vt[4]  = '{-36'sd16385,      -16'sd1,     1'b0};
        vt[5]  = '{-36'sd49152,      -16'sd1,     1'b0};
        vt[6]  = '{36'sd2147483648,  16'sd32767,  1'b1};
        vt[7]  = '{-36'sd2147483648, -16'sd32768, 1'b1};
        vt[8]  = '{36'sd1073709056,  16'sd32767,  1'b0};
        vt[9]  = '{36'sd1073725440,  16'sd32767,  1'b1};
        vt[10] = '{-36'sd1073758208, -16'sd32768, 1'b0};
        vt[11] = '{-36'sd1073758209, -16'sd32768, 1'b1};
        vt[12] = '{36'sh7FFFFFFFF,   16'sd32767,  1'b1};
        vt[13] = '{36'sh800000000,   -16'sd32768, 1'b1};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sat", out_sat, 0);
`ifdef CONV_RQ_SAT_COUNT_EN
        chk("rst_satcnt", sat_count, 0);
`endif

        // Rounding / saturation table, one word at a time, latency checked each time.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            push(vt[i].din);
            tick();
            chk($sformatf("v%0d_lat2", i), out_valid, 0);
            tick();
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_data", i), $signed(out_data), vt[i].dout);
            chk($sformatf("v%0d_sat", i), out_sat, vt[i].sat);
            tick();
            chk($sformatf("v%0d_level", i), fifo_level, 0);
        end
        chk("tbl_ovf", overflow, 0);
`ifdef CONV_RQ_SAT_COUNT_EN
        chk("tbl_satcnt", sat_count, 6);
`endif

        // Fill to full, then a new word lands on the same edge as a pop.
        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) push(longint'(k) * 32768);
        repeat (4) tick();
        chk("fp_level_full", fifo_level, 8);
        push(9 * 32768);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fp_level", fifo_level, 8);
        chk("fp_ovf", overflow, 0);
        chk("fp_head", $signed(out_data), 2);
        out_ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            chk($sformatf("fp_out%0d", k), $signed(out_data), k);
            tick();
        end
        chk("fp_empty", out_valid, 0);

        // Backpressure: nine inputs into eight slots, the ninth is lost.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            in_data = FW'(longint'(k) * 32768);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_level", fifo_level, 8);
        chk("bp_ovf", overflow, 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("bp_valid%0d", k), out_valid, 1);
            chk($sformatf("bp_out%0d", k), $signed(out_data), k);
            tick();
        end
        chk("bp_level0", fifo_level, 0);
        chk("bp_empty", out_valid, 0);
        chk("bp_ovf_sticky", overflow, 1);

        // Mid-stream reset with five words queued and two in the pipeline.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            in_data = FW'(longint'(k) * 32768);
            tick();
        end
        in_valid = 1'b0;
        chk("mr_pre_level", fifo_level, 5);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mr_valid", out_valid, 0);
        chk("mr_level", fifo_level, 0);
        chk("mr_ovf", overflow, 0);
        repeat (4) tick();
        chk("mr_nostale", out_valid, 0);
        chk("mr_nostale_lvl", fifo_level, 0);
        out_ready = 1'b1;
        push(11 * 32768);
        tick();
        chk("mr_fresh_lat2", out_valid, 0);
        tick();
        chk("mr_fresh_valid", out_valid, 1);
        chk("mr_fresh_data", $signed(out_data), 11);
        tick();
        chk("mr_fresh_drain", fifo_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
